// File: rtl/pll_ddr3_seq_pkg.sv
// Package for the DDR3 clock-PLL power-up / lock sequencer.
// Holds the sequencer state encoding, the loss-of-lock counter width and a
// small constant helper used to size the shared dwell counter.
package pll_seq_pkg;

    // Sequencer states; encodings are visible on the debug state output.
    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_WAIT = 3'd1,
        S_EN0  = 3'd2,
        S_EN2  = 3'd3,
        S_REL  = 3'd4,
        S_RUN  = 3'd5,
        S_FAIL = 3'd6
    } state_t;

    // Width of the saturating loss-of-lock event counter.
    localparam int LOL_CNT_W = 8;

    // Largest of four cycle counts; sizes the dwell counter shared by all states.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pll_ddr3_seq_if.sv
// Bundle of PLL-side and status signals between the lock sequencer and its
// surroundings (PLL wrapper, DDR3 controller, debug).
//   master : the sequencer -- drives PLL reset/enables, DDR reset and status
//   slave  : the environment -- drives pll_lock and soft_restart
// Parameter MAX_RETRY must match the sequencer instance; it sizes retry_cnt.
interface pll_ddr3_seq_if
    import pll_seq_pkg::*;
#(
    parameter int MAX_RETRY = 3
);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    logic                 pll_lock;
    logic                 soft_restart;
    logic                 pll_reset;
    logic                 enclk0;
    logic                 enclk2;
    logic                 ddr_rst_n;
    logic                 ready;
    logic                 fail;
    logic [RETRY_W-1:0]   retry_cnt;
    logic [LOL_CNT_W-1:0] lol_cnt;
    logic [2:0]           state;

    modport master (
        input  pll_lock, soft_restart,
        output pll_reset, enclk0, enclk2, ddr_rst_n, ready, fail,
               retry_cnt, lol_cnt, state
    );

    modport slave (
        output pll_lock, soft_restart,
        input  pll_reset, enclk0, enclk2, ddr_rst_n, ready, fail,
               retry_cnt, lol_cnt, state
    );
endinterface

// File: rtl/pll_ddr3_seq_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL LOCK into the
// reference-clock domain.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset (output reads 0 in reset)
//   d     : asynchronous input
//   q     : synchronized output, two cycles after d
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;
endmodule

// File: rtl/pll_ddr3_seq.sv
// Power-up and lock sequencer for the DDR3 clock PLL.
// Holds the PLL in reset, waits for a stable synchronized lock, enables
// CLKOUT0 then CLKOUT2, releases the DDR3 controller reset and then
// supervises lock. Failed lock attempts are retried up to MAX_RETRY times
// before the sequencer parks in S_FAIL.
//   clk   : PLL reference clock, the only clock
//   rst_n : asynchronous active-low reset
//   bus   : master side of pll_ddr3_seq_if (pll_lock/soft_restart in;
//           pll_reset, enclk0, enclk2, ddr_rst_n, ready, fail, retry_cnt,
//           lol_cnt, state out). All outputs are registered.
module pll_ddr3_seq
    import pll_seq_pkg::*;
#(
    parameter int RESET_HOLD_CYC  = 64,
    parameter int LOCK_STABLE_CYC = 1024,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int ENABLE_GAP_CYC  = 16,
    parameter int MAX_RETRY       = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    pll_ddr3_seq_if.master bus
);
    localparam int RETRY_W  = $clog2(MAX_RETRY + 1);
    localparam int DWELL_W  = $clog2(max4(RESET_HOLD_CYC, LOCK_STABLE_CYC,
                                          LOCK_TIMEOUT_CYC, ENABLE_GAP_CYC));
    localparam int STABLE_W = $clog2(LOCK_STABLE_CYC + 1);

    // Terminal counts: the transition fires on the last cycle of each dwell.
    localparam logic [DWELL_W-1:0]  HOLD_LAST    = DWELL_W'(RESET_HOLD_CYC - 1);
    localparam logic [DWELL_W-1:0]  TIMEOUT_LAST = DWELL_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [DWELL_W-1:0]  GAP_LAST     = DWELL_W'(ENABLE_GAP_CYC - 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST  = STABLE_W'(LOCK_STABLE_CYC - 1);
    localparam logic [RETRY_W-1:0]  RETRY_MAX    = RETRY_W'(MAX_RETRY);
    localparam logic [LOL_CNT_W-1:0] LOL_SAT     = {LOL_CNT_W{1'b1}};

    logic                 lock_s;
    state_t               state_r;
    state_t               next_state_s;
    state_t               cand_state_s;
    state_t               retry_state_s;
    logic [DWELL_W-1:0]   dwell_r;
    logic [STABLE_W-1:0]  stable_r;
    logic [RETRY_W-1:0]   retry_r;
    logic [RETRY_W-1:0]   next_retry_s;
    logic [RETRY_W-1:0]   cand_retry_s;
    logic [RETRY_W-1:0]   retry_inc_s;
    logic [LOL_CNT_W-1:0] lol_r;
    logic                 lol_inc_s;
    logic                 cand_lol_inc_s;
    logic                 restart_s;
    logic                 timed_state_s;
    logic                 pll_reset_s, enclk0_s, enclk2_s, ddr_rst_n_s, ready_s, fail_s;
    logic                 pll_reset_r, enclk0_r, enclk2_r, ddr_rst_n_r, ready_r, fail_r;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.pll_lock),
        .q     (lock_s)
    );

    // Outcome of a failed attempt: another try, or give up once retries are spent.
    always_comb begin
        retry_state_s = S_RST;
        retry_inc_s   = retry_r;
        if (retry_r == RETRY_MAX) begin
            retry_state_s = S_FAIL;
            retry_inc_s   = retry_r;
        end else begin
            retry_state_s = S_RST;
            retry_inc_s   = retry_r + 1'b1;
        end
    end

    // Next-state logic; soft_restart overrides every other transition.
    always_comb begin
        cand_state_s   = state_r;
        cand_retry_s   = retry_r;
        cand_lol_inc_s = 1'b0;
        case (state_r)
            S_RST: begin
                if (dwell_r == HOLD_LAST) cand_state_s = S_WAIT;
                else                      cand_state_s = S_RST;
            end
            S_WAIT: begin
                // Stable lock wins over a coincident timeout.
                if (lock_s && (stable_r == STABLE_LAST)) begin
                    cand_state_s = S_EN0;
                end else if (dwell_r == TIMEOUT_LAST) begin
                    cand_state_s = retry_state_s;
                    cand_retry_s = retry_inc_s;
                end else begin
                    cand_state_s = S_WAIT;
                end
            end
            S_EN0: begin
                if (!lock_s) begin
                    cand_state_s = retry_state_s;
                    cand_retry_s = retry_inc_s;
                end else if (dwell_r == GAP_LAST) begin
                    cand_state_s = S_EN2;
                end else begin
                    cand_state_s = S_EN0;
                end
            end
            S_EN2: begin
                if (!lock_s) begin
                    cand_state_s = retry_state_s;
                    cand_retry_s = retry_inc_s;
                end else if (dwell_r == GAP_LAST) begin
                    cand_state_s = S_REL;
                end else begin
                    cand_state_s = S_EN2;
                end
            end
            S_REL: begin
                if (!lock_s) begin
                    cand_state_s = retry_state_s;
                    cand_retry_s = retry_inc_s;
                end else begin
                    cand_state_s = S_RUN;
                end
            end
            S_RUN: begin
                // Loss of lock after bring-up restarts cleanly; it is not a retry.
                if (!lock_s) begin
                    cand_state_s   = S_RST;
                    cand_retry_s   = '0;
                    cand_lol_inc_s = 1'b1;
                end else begin
                    cand_state_s = S_RUN;
                end
            end
            S_FAIL: begin
                cand_state_s = S_FAIL;
            end
            default: begin
                cand_state_s = S_RST;
                cand_retry_s = '0;
            end
        endcase

        next_state_s = cand_state_s;
        next_retry_s = cand_retry_s;
        lol_inc_s    = cand_lol_inc_s;
        if (bus.soft_restart) begin
            next_state_s = S_RST;
            next_retry_s = '0;
            lol_inc_s    = 1'b0;
        end else begin
            next_state_s = cand_state_s;
            next_retry_s = cand_retry_s;
            lol_inc_s    = cand_lol_inc_s;
        end
    end

    // Restart of the shared dwell counter, and the states that time their dwell.
    assign restart_s     = (next_state_s != state_r) || bus.soft_restart;
    assign timed_state_s = (state_r == S_RST) || (state_r == S_WAIT) ||
                           (state_r == S_EN0) || (state_r == S_EN2);

    // Moore output decode from the next state, so outputs register with the state.
    always_comb begin
        pll_reset_s = 1'b0;
        enclk0_s    = 1'b0;
        enclk2_s    = 1'b0;
        ddr_rst_n_s = 1'b0;
        ready_s     = 1'b0;
        fail_s      = 1'b0;
        case (next_state_s)
            S_RST:  pll_reset_s = 1'b1;
            S_WAIT: pll_reset_s = 1'b0;
            S_EN0:  enclk0_s    = 1'b1;
            S_EN2: begin
                enclk0_s = 1'b1;
                enclk2_s = 1'b1;
            end
            S_REL: begin
                enclk0_s    = 1'b1;
                enclk2_s    = 1'b1;
                ddr_rst_n_s = 1'b1;
            end
            S_RUN: begin
                enclk0_s    = 1'b1;
                enclk2_s    = 1'b1;
                ddr_rst_n_s = 1'b1;
                ready_s     = 1'b1;
            end
            S_FAIL: begin
                pll_reset_s = 1'b1;
                fail_s      = 1'b1;
            end
            default: pll_reset_s = 1'b1;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_RST;
            dwell_r     <= '0;
            stable_r    <= '0;
            retry_r     <= '0;
            lol_r       <= '0;
            pll_reset_r <= 1'b1;
            enclk0_r    <= 1'b0;
            enclk2_r    <= 1'b0;
            ddr_rst_n_r <= 1'b0;
            ready_r     <= 1'b0;
            fail_r      <= 1'b0;
        end else begin
            state_r <= next_state_s;
            retry_r <= next_retry_s;

            if (restart_s || !timed_state_s) dwell_r <= '0;
            else                             dwell_r <= dwell_r + 1'b1;

            // Consecutive lock-high run, only meaningful while waiting for lock.
            if ((state_r == S_WAIT) && !restart_s && lock_s) stable_r <= stable_r + 1'b1;
            else                                             stable_r <= '0;

            if (lol_inc_s && (lol_r != LOL_SAT)) lol_r <= lol_r + 1'b1;
            else                                 lol_r <= lol_r;

            pll_reset_r <= pll_reset_s;
            enclk0_r    <= enclk0_s;
            enclk2_r    <= enclk2_s;
            ddr_rst_n_r <= ddr_rst_n_s;
            ready_r     <= ready_s;
            fail_r      <= fail_s;
        end
    end

    assign bus.pll_reset = pll_reset_r;
    assign bus.enclk0    = enclk0_r;
    assign bus.enclk2    = enclk2_r;
    assign bus.ddr_rst_n = ddr_rst_n_r;
    assign bus.ready     = ready_r;
    assign bus.fail      = fail_r;
    assign bus.retry_cnt = retry_r;
    assign bus.lol_cnt   = lol_r;
    assign bus.state     = state_r;
endmodule

// File: tb/tb_pll_ddr3_seq.sv
// Directed bench for pll_ddr3_seq with small parameters
// (hold 4, stable 8, gap 2, timeout 32, max retry 2).
module tb_pll_ddr3_seq;
    import pll_seq_pkg::*;

    localparam int HOLD    = 4;
    localparam int STABLE  = 8;
    localparam int GAP     = 2;
    localparam int TIMEOUT = 32;
    localparam int MAXR    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pll_ddr3_seq_if #(.MAX_RETRY(MAXR)) bus ();

    pll_ddr3_seq #(
        .RESET_HOLD_CYC   (HOLD),
        .LOCK_STABLE_CYC  (STABLE),
        .LOCK_TIMEOUT_CYC (TIMEOUT),
        .ENABLE_GAP_CYC   (GAP),
        .MAX_RETRY        (MAXR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
        int n;
        n = 0;
        while (bus.state !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {29'd0, bus.state}, {29'd0, target});
    endtask

    initial begin
        int t_en0, t_en2, t_ddr, t_rdy, n;
        bus.pll_lock     = 1'b1;
        bus.soft_restart = 1'b0;
        tick(2);

        // Reset state
        check("rst_state",     {29'd0, bus.state}, 32'd0);
        check("rst_pll_reset", {31'd0, bus.pll_reset}, 32'd1);
        check("rst_enclk0",    {31'd0, bus.enclk0}, 32'd0);
        check("rst_enclk2",    {31'd0, bus.enclk2}, 32'd0);
        check("rst_ddr_rst_n", {31'd0, bus.ddr_rst_n}, 32'd0);
        check("rst_ready",     {31'd0, bus.ready}, 32'd0);
        check("rst_fail",      {31'd0, bus.fail}, 32'd0);
        check("rst_retry",     {30'd0, bus.retry_cnt}, 32'd0);
        check("rst_lol",       {24'd0, bus.lol_cnt}, 32'd0);

        // 1: lock high from reset; record the cycle each output first rises
        rst_n = 1'b1;
        t_en0 = 0; t_en2 = 0; t_ddr = 0; t_rdy = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.enclk0    === 1'b1 && t_en0 == 0) t_en0 = c;
            if (bus.enclk2    === 1'b1 && t_en2 == 0) t_en2 = c;
            if (bus.ddr_rst_n === 1'b1 && t_ddr == 0) t_ddr = c;
            if (bus.ready     === 1'b1 && t_rdy == 0) t_rdy = c;
        end
        check("t1_enclk0_cycle", t_en0, 32'd12);
        check("t1_enclk2_cycle", t_en2, 32'd14);
        check("t1_ddr_cycle",    t_ddr, 32'd16);
        check("t1_ready_cycle",  t_rdy, 32'd17);
        check("t1_state_run",    {29'd0, bus.state}, 32'd5);

        // 3: one-cycle lock drop in S_RUN
        bus.pll_lock = 1'b0;
        tick(1);
        bus.pll_lock = 1'b1;
        tick(1);
        check("t3_ready_still_up", {31'd0, bus.ready}, 32'd1);
        tick(1);
        check("t3_ready_low",   {31'd0, bus.ready}, 32'd0);
        check("t3_enclk0_low",  {31'd0, bus.enclk0}, 32'd0);
        check("t3_enclk2_low",  {31'd0, bus.enclk2}, 32'd0);
        check("t3_ddr_low",     {31'd0, bus.ddr_rst_n}, 32'd0);
        check("t3_pll_reset",   {31'd0, bus.pll_reset}, 32'd1);
        check("t3_lol_cnt",     {24'd0, bus.lol_cnt}, 32'd1);
        check("t3_state",       {29'd0, bus.state}, 32'd0);
        check("t3_retry",       {30'd0, bus.retry_cnt}, 32'd0);
        tick(16);
        check("t3_ready_16",    {31'd0, bus.ready}, 32'd0);
        tick(1);
        check("t3_ready_17",    {31'd0, bus.ready}, 32'd1);

        // 4: lock loss arriving in S_EN2
        bus.soft_restart = 1'b1;
        tick(1);
        bus.soft_restart = 1'b0;
        check("t4_restart_state", {29'd0, bus.state}, 32'd0);
        wait_state("t4_reach_en0", 3'd2, 40);
        bus.pll_lock = 1'b0;
        tick(2);
        check("t4_in_en2",     {29'd0, bus.state}, 32'd3);
        tick(1);
        check("t4_state_rst",  {29'd0, bus.state}, 32'd0);
        check("t4_enclk0_low", {31'd0, bus.enclk0}, 32'd0);
        check("t4_enclk2_low", {31'd0, bus.enclk2}, 32'd0);
        check("t4_pll_reset",  {31'd0, bus.pll_reset}, 32'd1);
        check("t4_retry",      {30'd0, bus.retry_cnt}, 32'd1);
        bus.pll_lock = 1'b1;
        wait_state("t4_back_to_run", 3'd5, 60);

        // 6: asynchronous reset in S_RUN
        #2 rst_n = 1'b0;
        #1;
        check("t6_state",     {29'd0, bus.state}, 32'd0);
        check("t6_pll_reset", {31'd0, bus.pll_reset}, 32'd1);
        check("t6_enclk0",    {31'd0, bus.enclk0}, 32'd0);
        check("t6_enclk2",    {31'd0, bus.enclk2}, 32'd0);
        check("t6_ddr",       {31'd0, bus.ddr_rst_n}, 32'd0);
        check("t6_ready",     {31'd0, bus.ready}, 32'd0);
        check("t6_lol",       {24'd0, bus.lol_cnt}, 32'd0);
        check("t6_retry",     {30'd0, bus.retry_cnt}, 32'd0);
        @(negedge clk);

        // 2: lock toggling every 5 cycles never qualifies; retries run out
        bus.pll_lock = 1'b0;
        rst_n = 1'b1;
        n = 0;
        while (bus.fail !== 1'b1 && n < 400) begin
            if (n % 5 == 0) bus.pll_lock = ~bus.pll_lock;
            @(negedge clk);
            n++;
        end
        tick(3);
        check("t2_fail",      {31'd0, bus.fail}, 32'd1);
        check("t2_retry",     {30'd0, bus.retry_cnt}, 32'd2);
        check("t2_state",     {29'd0, bus.state}, 32'd6);
        check("t2_pll_reset", {31'd0, bus.pll_reset}, 32'd1);
        check("t2_enclk0",    {31'd0, bus.enclk0}, 32'd0);
        bus.pll_lock = 1'b0;
        bus.soft_restart = 1'b1;
        tick(1);
        bus.soft_restart = 1'b0;
        check("t2_sr_state", {29'd0, bus.state}, 32'd0);
        check("t2_sr_fail",  {31'd0, bus.fail}, 32'd0);
        check("t2_sr_retry", {30'd0, bus.retry_cnt}, 32'd0);

        // 5: soft_restart coincident with the final timeout
        n = 0;
        while (!(bus.state === 3'd1 && bus.retry_cnt === 2'd2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t5_wait_state", {29'd0, bus.state}, 32'd1);
        check("t5_wait_retry", {30'd0, bus.retry_cnt}, 32'd2);
        tick(30);
        check("t5_pre_timeout", {29'd0, bus.state}, 32'd1);
        tick(1);
        bus.soft_restart = 1'b1;
        tick(1);
        bus.soft_restart = 1'b0;
        check("t5_state", {29'd0, bus.state}, 32'd0);
        check("t5_retry", {30'd0, bus.retry_cnt}, 32'd0);
        check("t5_fail",  {31'd0, bus.fail}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
